hill_cipher_stream: RTL and testbench
=====================================

# hill_cipher_stream

Streaming, parametrised Hill-cipher engine: accepts ASCII letters over a valid/ready input, groups them into BLOCK_SIZE vectors, and multiplies each by a BLOCK_SIZE×BLOCK_SIZE key modulo MODULUS. It emits ASCII over a valid/ready output with backpressure. Two key banks (encrypt, decrypt) select per message; partial final blocks are padded. It sits between the host text interface and the output formatter, replacing the single-block, start/done crypto core.

## Interface
- BLOCK_SIZE, 3, block length N; key is N×N
- DATA_WIDTH, 8, character width (ASCII)
- MODULUS, 26, alphabet size
- PAD_VAL, 23, symbol used to pad a short final block ('X')
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- key_wen  in  1  key write strobe
- key_bank  in  1  0 = encrypt bank, 1 = decrypt bank
- key_addr  in  $clog2(N*N)  row-major index, r*N+c
- key_data  in  DATA_WIDTH  key element, 0..MODULUS-1
- mode  in  1  bank used for the block; sampled on the block's first accepted letter
- in_valid / in_ready  in / out  1  input handshake
- in_data  in  DATA_WIDTH  ASCII character
- in_last  in  1  marks final character of message
- out_valid / out_ready  out / in  1  output handshake
- out_data  out  DATA_WIDTH  ASCII 'A'+symbol
- out_last  out  1  final output character of message
- busy  out  1  state ≠ COLLECT or count ≠ 0
- err_char  out  1  one-cycle pulse: non-letter discarded
- err_key  out  1  one-cycle pulse: key write ignored
- done  out  1  one-cycle pulse: message complete

## Operation
- States: COLLECT, COMPUTE, EMIT.
- COLLECT: in_ready=1. Each handshake with 'A'..'Z' stores in_data-'A' at vec[count] and increments count. Other characters are accepted, dropped, and pulse err_char. Block closes when count reaches N, or when in_last is handshaken with count>0; missing slots fill with PAD_VAL. in_last with count==0 (e.g. on a dropped char): no block, done pulses next cycle.
- COMPUTE: in_ready=0. One MAC per cycle, row r, column c: acc ← (acc + key[r][c]·vec[c]) mod MODULUS. acc is reset at c=0 and stored to res[r] at c=N-1. Product width 2·$clog2(MODULUS); reduction occurs every step, so acc never exceeds MODULUS-1.
- EMIT: out_valid=1, out_data='A'+res[idx]. idx advances on out_ready. out_last=1 on idx N-1 of a block closed by in_last. After the final handshake: return to COLLECT, count=0, done pulses if the block was last.
- Key writes: accepted only when busy=0. Otherwise ignored with an err_key pulse. Same-cycle key_wen and input handshake are both honoured.
- Reset: state COLLECT, count/idx 0. Both key banks cleared to 0. All outputs 0 except in_ready=1. Reset mid-block discards partial data and any pending output.

## Timing
- Load: 1 cycle per letter; N-letter block needs N cycles minimum.
- COMPUTE: exactly N·N cycles. out_valid first high N·N edges after the edge accepting the closing character (9 for N=3).
- EMIT: N cycles with out_ready held 1. out_ready low stalls EMIT indefinitely, and out_data is stable while out_valid=1 and out_ready=0.
- Throughput with no stalls: one block per N + N·N + N cycles.
- done, err_char, err_key: registered, high exactly one cycle.

## Configuration
- HILL_CASE_FOLD_EN defined: 'a'..'z' are accepted as letters (symbol in_data-'a'). Output stays uppercase.
- HILL_CASE_FOLD_EN undefined: lowercase is non-letter, dropped with err_char.

## Structure
- Package hill_pkg: state enum, ASCII_A/ASCII_Z/ASCII_LA constants, symbol-width and index-width functions.
- One sub-module, hill_mac_mod: registered accumulate-and-reduce unit (key element, vec element, clear, enable → acc).
- Top module holds the key banks, vector/result buffers, FSM, and handshakes.

## Test plan
- Key GYBNQKURP (6,24,1,13,16,10,20,17,15) in bank 0, mode 0, "ACT"+in_last → "POH", out_last on 'H', done one cycle after the 'H' handshake.
- Inverse key (8,5,10,21,8,21,21,12,8) in bank 1, mode 1, "POH" → "ACT".
- Encrypt bank, "AC"+in_last → padded [0,2,23] → "TCP".
- "A1CT" → err_char pulse on '1', output "POH". Key write during COMPUTE → err_key, keys unchanged.
- out_ready toggled 1/0 every cycle during EMIT → "POH" intact, out_data stable while stalled. rst_n low during COMPUTE → no output, busy=0, later "ACT" → "POH" after key reload.
- With HILL_CASE_FOLD_EN: "act" → "POH". Without it: three err_char pulses, no output.

Source files
------------

// File: rtl/hill_pkg.sv
// Shared definitions for the Hill-cipher streaming engine.
//   - state_t        : COLLECT / COMPUTE / EMIT controller states
//   - ASCII_*        : character codes used for letter detection and output
//   - sym_width()    : bits needed for one symbol 0..modulus-1
//   - idx_width()    : bits needed to index 0..n-1 (at least 1)
package hill_pkg;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_EMIT    = 2'd2
    } state_t;

    localparam logic [7:0] ASCII_A  = 8'h41;
    localparam logic [7:0] ASCII_Z  = 8'h5A;
    localparam logic [7:0] ASCII_LA = 8'h61;
    localparam logic [7:0] ASCII_LZ = 8'h7A;

    function automatic int sym_width(input int modulus);
        return (modulus > 2) ? $clog2(modulus) : 1;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hill_mac_mod.sv
// Accumulate-and-reduce unit for one matrix-row dot product.
// Each enabled cycle: acc_r <= ((clear ? 0 : acc_r) + key_elem * vec_elem) mod MODULUS.
// The reduction happens every step, so the held value never exceeds MODULUS-1.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   clear               : start a new row (ignore the held accumulator)
//   enable              : perform one MAC step this cycle
//   key_elem, vec_elem  : operands, each 0..MODULUS-1
//   acc                 : reduced sum including this cycle's product; it is the
//                         value the accumulator register takes at the next edge,
//                         so the caller can store a finished row on the same edge
module hill_mac_mod
    import hill_pkg::*;
#(
    parameter int MODULUS = 26,
    parameter int SW      = sym_width(MODULUS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          enable,
    input  logic [SW-1:0] key_elem,
    input  logic [SW-1:0] vec_elem,
    output logic [SW-1:0] acc
);

    localparam int PW   = 2 * SW;
    localparam int SUMW = PW + 1;

    logic [SW-1:0]   acc_r;
    logic [SW-1:0]   base_s;
    logic [PW-1:0]   prod_s;
    logic [SUMW-1:0] sum_s;

    // Product, running sum and modular reduction for the current step
    always_comb begin
        prod_s = PW'(key_elem) * PW'(vec_elem);
        if (clear) begin
            base_s = '0;
        end else begin
            base_s = acc_r;
        end
        sum_s = SUMW'(prod_s) + SUMW'(base_s);
        acc   = SW'(sum_s % SUMW'(MODULUS));
    end

    // Accumulator register, advanced only on enabled steps
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_r <= '0;
        end else if (enable) begin
            acc_r <= acc;
        end else begin
            acc_r <= acc_r;
        end
    end

endmodule

// File: rtl/hill_cipher_stream.sv
// Streaming Hill-cipher engine.
// Letters arrive over in_valid/in_ready, are grouped into BLOCK_SIZE-symbol
// vectors, multiplied by a BLOCK_SIZE x BLOCK_SIZE key (mod MODULUS) one MAC per
// cycle, and leave as uppercase ASCII over out_valid/out_ready.
// Two key banks (0 = encrypt, 1 = decrypt); the bank is latched from 'mode'
// on the first letter of each block. Short final blocks are padded with PAD_VAL.
// Optional feature macro: HILL_CASE_FOLD_EN -- when defined, 'a'..'z' are
// accepted as letters; otherwise lowercase is dropped with err_char.
// Ports:
//   clk, rst_n                       : clock, synchronous active-low reset
//   key_wen/key_bank/key_addr/key_data: key element write (row-major r*N+c)
//   mode                             : bank for the block being collected
//   in_valid/in_ready/in_data/in_last: character input stream
//   out_valid/out_ready/out_data/out_last: ciphertext output stream
//   busy                             : block in progress (not idle COLLECT)
//   err_char, err_key, done          : single-cycle status pulses
module hill_cipher_stream
    import hill_pkg::*;
#(
    parameter int BLOCK_SIZE = 3,
    parameter int DATA_WIDTH = 8,
    parameter int MODULUS    = 26,
    parameter int PAD_VAL    = 23
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   key_wen,
    input  logic                                   key_bank,
    input  logic [$clog2(BLOCK_SIZE*BLOCK_SIZE)-1:0] key_addr,
    input  logic [DATA_WIDTH-1:0]                  key_data,
    input  logic                                   mode,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [DATA_WIDTH-1:0]                  in_data,
    input  logic                                   in_last,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [DATA_WIDTH-1:0]                  out_data,
    output logic                                   out_last,
    output logic                                   busy,
    output logic                                   err_char,
    output logic                                   err_key,
    output logic                                   done
);

    localparam int N   = BLOCK_SIZE;
    localparam int NN  = N * N;
    localparam int SW  = sym_width(MODULUS);
    localparam int IW  = idx_width(N);
    localparam int CW  = $clog2(N + 1);
    localparam int KAW = $clog2(NN);

    localparam logic [DATA_WIDTH-1:0] CH_A  = DATA_WIDTH'(ASCII_A);
    localparam logic [DATA_WIDTH-1:0] CH_Z  = DATA_WIDTH'(ASCII_Z);
`ifdef HILL_CASE_FOLD_EN
    localparam logic [DATA_WIDTH-1:0] CH_LA = DATA_WIDTH'(ASCII_LA);
    localparam logic [DATA_WIDTH-1:0] CH_LZ = DATA_WIDTH'(ASCII_LZ);
`endif

    function automatic logic [DATA_WIDTH-1:0] to_ascii(input logic [SW-1:0] s);
        return CH_A + DATA_WIDTH'(s);
    endfunction

    // Controller and datapath state
    state_t                state_r;
    logic [CW-1:0]         count_r;
    logic [IW-1:0]         row_r;
    logic [IW-1:0]         col_r;
    logic [IW-1:0]         idx_r;
    logic                  bank_r;
    logic                  last_blk_r;
    logic [SW-1:0]         vec_r [N];
    logic [SW-1:0]         res_r [N];
    logic [SW-1:0]         key_r [2][NN];

    // Registered outputs
    logic                  in_ready_r;
    logic                  busy_r;
    logic                  out_valid_r;
    logic [DATA_WIDTH-1:0] out_data_r;
    logic                  out_last_r;
    logic                  err_char_r;
    logic                  err_key_r;
    logic                  done_r;

    // Combinational helpers
    logic                  in_hs_s;
    logic                  out_hs_s;
    logic                  is_letter_s;
    logic [SW-1:0]         sym_s;
    logic [CW-1:0]         fill_cnt_s;
    logic                  close_s;
    logic [KAW-1:0]        key_idx_s;
    logic                  mac_en_s;
    logic                  mac_clear_s;
    logic [SW-1:0]         mac_key_s;
    logic [SW-1:0]         mac_vec_s;
    logic [SW-1:0]         mac_acc_s;

    assign in_ready  = in_ready_r;
    assign busy      = busy_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_last  = out_last_r;
    assign err_char  = err_char_r;
    assign err_key   = err_key_r;
    assign done      = done_r;

    // Handshakes, letter classification and block-close decision
    always_comb begin
        in_hs_s  = in_valid && in_ready_r;
        out_hs_s = out_valid_r && out_ready;

        if ((in_data >= CH_A) && (in_data <= CH_Z)) begin
            is_letter_s = 1'b1;
            sym_s       = SW'(in_data - CH_A);
        end
`ifdef HILL_CASE_FOLD_EN
        else if ((in_data >= CH_LA) && (in_data <= CH_LZ)) begin
            is_letter_s = 1'b1;
            sym_s       = SW'(in_data - CH_LA);
        end
`endif
        else begin
            is_letter_s = 1'b0;
            sym_s       = '0;
        end

        // Number of filled slots once this character has been absorbed
        if (is_letter_s) begin
            fill_cnt_s = count_r + CW'(1);
        end else begin
            fill_cnt_s = count_r;
        end

        // A block closes when full, or when the message ends with data pending
        close_s = in_hs_s &&
                  ((is_letter_s && (fill_cnt_s == CW'(N))) ||
                   (in_last && (fill_cnt_s != CW'(0))));
    end

    // MAC operand selection: key[row][col] times vec[col]
    always_comb begin
        key_idx_s   = KAW'(int'(row_r) * N + int'(col_r));
        mac_en_s    = (state_r == ST_COMPUTE);
        mac_clear_s = (col_r == IW'(0));
        mac_key_s   = key_r[bank_r][key_idx_s];
        mac_vec_s   = vec_r[col_r];
    end

    hill_mac_mod #(
        .MODULUS (MODULUS),
        .SW      (SW)
    ) u_mac (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (mac_clear_s),
        .enable   (mac_en_s),
        .key_elem (mac_key_s),
        .vec_elem (mac_vec_s),
        .acc      (mac_acc_s)
    );

    // Key banks: written only while idle; writes while busy are dropped and flagged
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < NN; i++) begin
                    key_r[b][i] <= '0;
                end
            end
            err_key_r <= 1'b0;
        end else begin
            err_key_r <= 1'b0;
            if (key_wen) begin
                if (busy_r) begin
                    err_key_r <= 1'b1;
                end else if (int'(key_addr) < NN) begin
                    // Out-of-range values are folded into the alphabet
                    key_r[key_bank][key_addr] <= SW'(key_data % DATA_WIDTH'(MODULUS));
                end
            end
        end
    end

    // Block controller: collect letters, run N*N MAC steps, emit N characters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_COLLECT;
            count_r     <= '0;
            row_r       <= '0;
            col_r       <= '0;
            idx_r       <= '0;
            bank_r      <= 1'b0;
            last_blk_r  <= 1'b0;
            for (int i = 0; i < N; i++) begin
                vec_r[i] <= '0;
                res_r[i] <= '0;
            end
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_last_r  <= 1'b0;
            err_char_r  <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            err_char_r <= 1'b0;
            done_r     <= 1'b0;
            case (state_r)
                ST_COLLECT: begin
                    if (in_hs_s) begin
                        if (is_letter_s) begin
                            vec_r[IW'(count_r)] <= sym_s;
                            if (count_r == CW'(0)) begin
                                bank_r <= mode;
                            end
                        end else begin
                            err_char_r <= 1'b1;
                        end
                        if (close_s) begin
                            // Pad the unfilled tail; the letter slot is below fill_cnt_s
                            for (int i = 0; i < N; i++) begin
                                if (CW'(i) >= fill_cnt_s) begin
                                    vec_r[i] <= SW'(PAD_VAL);
                                end
                            end
                            last_blk_r <= in_last;
                            state_r    <= ST_COMPUTE;
                            count_r    <= '0;
                            row_r      <= '0;
                            col_r      <= '0;
                            in_ready_r <= 1'b0;
                            busy_r     <= 1'b1;
                        end else begin
                            count_r <= fill_cnt_s;
                            busy_r  <= (fill_cnt_s != CW'(0));
                            // Message ended with nothing buffered: finish immediately
                            if (in_last) begin
                                done_r <= 1'b1;
                            end
                        end
                    end
                end

                ST_COMPUTE: begin
                    if (col_r == IW'(N - 1)) begin
                        res_r[row_r] <= mac_acc_s;
                        col_r        <= '0;
                        if (row_r == IW'(N - 1)) begin
                            state_r     <= ST_EMIT;
                            idx_r       <= '0;
                            out_valid_r <= 1'b1;
                            out_last_r  <= last_blk_r && (N == 1);
                            // Row 0 is only being stored now when the block is 1x1
                            if (row_r == IW'(0)) begin
                                out_data_r <= to_ascii(mac_acc_s);
                            end else begin
                                out_data_r <= to_ascii(res_r[0]);
                            end
                        end else begin
                            row_r <= row_r + IW'(1);
                        end
                    end else begin
                        col_r <= col_r + IW'(1);
                    end
                end

                ST_EMIT: begin
                    if (out_hs_s) begin
                        if (idx_r == IW'(N - 1)) begin
                            state_r     <= ST_COLLECT;
                            idx_r       <= '0;
                            count_r     <= '0;
                            out_valid_r <= 1'b0;
                            out_last_r  <= 1'b0;
                            out_data_r  <= '0;
                            in_ready_r  <= 1'b1;
                            busy_r      <= 1'b0;
                            if (last_blk_r) begin
                                done_r <= 1'b1;
                            end
                        end else begin
                            idx_r      <= idx_r + IW'(1);
                            out_data_r <= to_ascii(res_r[idx_r + IW'(1)]);
                            out_last_r <= last_blk_r && ((idx_r + IW'(1)) == IW'(N - 1));
                        end
                    end
                end

                default: begin
                    state_r     <= ST_COLLECT;
                    count_r     <= '0;
                    idx_r       <= '0;
                    in_ready_r  <= 1'b1;
                    busy_r      <= 1'b0;
                    out_valid_r <= 1'b0;
                    out_last_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hill_cipher_stream.sv
// Directed testbench for hill_cipher_stream (N=3, MODULUS=26).
// Handles both builds of HILL_CASE_FOLD_EN.
module tb_hill_cipher_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_wen;
    logic        key_bank;
    logic [3:0]  key_addr;
    logic [7:0]  key_data;
    logic        mode;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic        busy;
    logic        err_char;
    logic        err_key;
    logic        done;

    int checks = 0;
    int errors = 0;

    int enc_key [9] = '{6, 24, 1, 13, 16, 10, 20, 17, 15};
    int dec_key [9] = '{8, 5, 10, 21, 8, 21, 21, 12, 8};

    localparam logic [23:0] S_POH = 24'h504F48;
    localparam logic [23:0] S_ACT = 24'h414354;
    localparam logic [23:0] S_TCP = 24'h544350;
    localparam logic [23:0] S_AAA = 24'h414141;

    always #5 clk = ~clk;

    hill_cipher_stream dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_wen   (key_wen),
        .key_bank  (key_bank),
        .key_addr  (key_addr),
        .key_data  (key_data),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .err_char  (err_char),
        .err_key   (err_key),
        .done      (done)
    );

    // All tasks start and end 1 time unit after a rising edge.
    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic write_key(input logic b, input int a, input int d);
        key_wen  = 1'b1;
        key_bank = b;
        key_addr = 4'(a);
        key_data = 8'(d);
        @(posedge clk);
        #1;
        key_wen  = 1'b0;
    endtask

    task automatic load_keys();
        for (int i = 0; i < 9; i++) write_key(1'b0, i, enc_key[i]);
        for (int i = 0; i < 9; i++) write_key(1'b1, i, dec_key[i]);
    endtask

    task automatic send_char(input logic [7:0] c, input logic lst, output logic err_o, output logic done_o);
        int n = 0;
        in_valid = 1'b1;
        in_data  = c;
        in_last  = lst;
        while (!in_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL send_timeout in_ready stayed %b, required 1", in_ready);
        end
        @(posedge clk);
        #1;
        err_o    = err_char;
        done_o   = done;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_str(input string s, input logic lst, output int errs, output logic done_o);
        logic e, d;
        errs = 0;
        done_o = 1'b0;
        for (int i = 0; i < s.len(); i++) begin
            send_char(s[i], lst && (i == s.len() - 1), e, d);
            if (e) errs++;
            done_o = d;
        end
    endtask

    // Collects one block; data holds first char in [23:16], lasts[k] is out_last of char k.
    task automatic recv_block(input bit toggle, output logic [23:0] data, output logic [2:0] lasts,
                              output logic done_o, output logic stable_o, output int first_o);
        int k = 0;
        int w = 0;
        logic [7:0] held = 8'h00;
        logic stalled = 1'b0;
        data = '0;
        lasts = '0;
        stable_o = 1'b1;
        first_o = -1;
        while (k < 3 && w < 200) begin
            out_ready = toggle ? (w % 2 == 0) : 1'b1;
            if (stalled && out_valid && (out_data !== held)) stable_o = 1'b0;
            stalled = 1'b0;
            if (out_valid && first_o < 0) first_o = w;
            if (out_valid && out_ready) begin
                data[8*(2-k) +: 8] = out_data;
                lasts[k] = out_last;
                k++;
            end else if (out_valid) begin
                stalled = 1'b1;
                held = out_data;
            end
            @(posedge clk);
            #1;
            w++;
        end
        done_o = done;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h want 00", out_data); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b want 0", out_last); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if ({err_char, err_key, done} !== 3'b000) begin errors++; $display("FAIL reset_pulses got %b want 000", {err_char, err_key, done}); end
    endtask

    task automatic test_encrypt();
        int errs, first; logic dn, st; logic [23:0] d; logic [2:0] l;
        mode = 1'b0;
        send_str("ACT", 1'b1, errs, dn);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL enc_busy got %b want 1", busy); end
        recv_block(1'b0, d, l, dn, st, first);
        checks++; if (d !== S_POH) begin errors++; $display("FAIL enc_data got %h want %h", d, S_POH); end
        checks++; if (l !== 3'b100) begin errors++; $display("FAIL enc_last got %b want 100", l); end
        checks++; if (first !== 9) begin errors++; $display("FAIL enc_latency got %0d want 9", first); end
        checks++; if (dn !== 1'b1) begin errors++; $display("FAIL enc_done got %b want 1", dn); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL enc_done_pulse got %b want 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL enc_idle got %b want 0", busy); end
    endtask

    task automatic test_decrypt();
        int errs, first; logic dn, st; logic [23:0] d; logic [2:0] l;
        mode = 1'b1;
        send_str("POH", 1'b1, errs, dn);
        mode = 1'b0;
        recv_block(1'b0, d, l, dn, st, first);
        checks++; if (d !== S_ACT) begin errors++; $display("FAIL dec_data got %h want %h", d, S_ACT); end
        checks++; if (l !== 3'b100) begin errors++; $display("FAIL dec_last got %b want 100", l); end
    endtask

    task automatic test_pad();
        int errs, first; logic dn, st; logic [23:0] d; logic [2:0] l;
        mode = 1'b0;
        send_str("AC", 1'b1, errs, dn);
        recv_block(1'b0, d, l, dn, st, first);
        checks++; if (d !== S_TCP) begin errors++; $display("FAIL pad_data got %h want %h", d, S_TCP); end
        checks++; if (first !== 9) begin errors++; $display("FAIL pad_latency got %0d want 9", first); end
        checks++; if (dn !== 1'b1) begin errors++; $display("FAIL pad_done got %b want 1", dn); end
    endtask

    task automatic test_err_char();
        int errs, first; logic dn, st; logic [23:0] d; logic [2:0] l;
        send_str("A1CT", 1'b1, errs, dn);
        checks++; if (errs !== 1) begin errors++; $display("FAIL errchar_count got %0d want 1", errs); end
        recv_block(1'b0, d, l, dn, st, first);
        checks++; if (d !== S_POH) begin errors++; $display("FAIL errchar_data got %h want %h", d, S_POH); end
    endtask

    task automatic test_key_busy();
        int errs, first; logic dn, st; logic [23:0] d; logic [2:0] l;
        send_str("ACT", 1'b1, errs, dn);
        write_key(1'b0, 0, 5);
        checks++; if (err_key !== 1'b1) begin errors++; $display("FAIL keybusy_err got %b want 1", err_key); end
        @(posedge clk); #1;
        checks++; if (err_key !== 1'b0) begin errors++; $display("FAIL keybusy_pulse got %b want 0", err_key); end
        recv_block(1'b0, d, l, dn, st, first);
        checks++; if (d !== S_POH) begin errors++; $display("FAIL keybusy_data got %h want %h", d, S_POH); end
        send_str("ACT", 1'b1, errs, dn);
        recv_block(1'b0, d, l, dn, st, first);
        checks++; if (d !== S_POH) begin errors++; $display("FAIL keybusy_keep got %h want %h", d, S_POH); end
    endtask

    task automatic test_stall();
        int errs, first; logic dn, st; logic [23:0] d; logic [2:0] l;
        send_str("ACT", 1'b1, errs, dn);
        recv_block(1'b1, d, l, dn, st, first);
        checks++; if (d !== S_POH) begin errors++; $display("FAIL stall_data got %h want %h", d, S_POH); end
        checks++; if (st !== 1'b1) begin errors++; $display("FAIL stall_stable got %b want 1", st); end
        checks++; if (l !== 3'b100) begin errors++; $display("FAIL stall_last got %b want 100", l); end
    endtask

    task automatic test_two_blocks();
        int errs, first; logic dn, st; logic [23:0] d; logic [2:0] l;
        send_str("ACT", 1'b0, errs, dn);
        recv_block(1'b0, d, l, dn, st, first);
        checks++; if (l !== 3'b000) begin errors++; $display("FAIL blk1_last got %b want 000", l); end
        checks++; if (dn !== 1'b0) begin errors++; $display("FAIL blk1_done got %b want 0", dn); end
        send_str("AC", 1'b1, errs, dn);
        recv_block(1'b0, d, l, dn, st, first);
        checks++; if (d !== S_TCP) begin errors++; $display("FAIL blk2_data got %h want %h", d, S_TCP); end
        checks++; if ({l, dn} !== 4'b1001) begin errors++; $display("FAIL blk2_last_done got %b want 1001", {l, dn}); end
    endtask

    task automatic test_mid_reset();
        int errs, first, seen; logic dn, st; logic [23:0] d; logic [2:0] l;
        send_str("ACT", 1'b1, errs, dn);
        repeat (3) @(posedge clk);
        #1;
        do_reset();
        checks++; if ({busy, in_ready, out_valid} !== 3'b010) begin errors++; $display("FAIL rst_state got %b want 010", {busy, in_ready, out_valid}); end
        seen = 0;
        repeat (20) begin @(posedge clk); #1; if (out_valid) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rst_no_output got %0d want 0", seen); end
        send_str("ACT", 1'b1, errs, dn);
        recv_block(1'b0, d, l, dn, st, first);
        checks++; if (d !== S_AAA) begin errors++; $display("FAIL rst_keys_clear got %h want %h", d, S_AAA); end
        load_keys();
        send_str("ACT", 1'b1, errs, dn);
        recv_block(1'b0, d, l, dn, st, first);
        checks++; if (d !== S_POH) begin errors++; $display("FAIL rst_reload got %h want %h", d, S_POH); end
    endtask

    task automatic test_case_fold();
        int errs, first, seen; logic dn, st; logic [23:0] d; logic [2:0] l;
        send_str("act", 1'b1, errs, dn);
`ifdef HILL_CASE_FOLD_EN
        recv_block(1'b0, d, l, dn, st, first);
        checks++; if (d !== S_POH) begin errors++; $display("FAIL fold_data got %h want %h", d, S_POH); end
        checks++; if (errs !== 0) begin errors++; $display("FAIL fold_err got %0d want 0", errs); end
`else
        checks++; if (errs !== 3) begin errors++; $display("FAIL lower_err got %0d want 3", errs); end
        checks++; if (dn !== 1'b1) begin errors++; $display("FAIL lower_done got %b want 1", dn); end
        seen = 0;
        repeat (15) begin @(posedge clk); #1; if (out_valid) seen++; end
        checks++; if ({seen != 0, busy} !== 2'b00) begin errors++; $display("FAIL lower_idle got %b want 00", {seen != 0, busy}); end
`endif
    endtask

    initial begin
        rst_n = 1'b0; key_wen = 1'b0; key_bank = 1'b0; key_addr = 4'd0; key_data = 8'd0;
        mode = 1'b0; in_valid = 1'b0; in_data = 8'd0; in_last = 1'b0; out_ready = 1'b0;
        #1;
        test_reset();
        load_keys();
        test_encrypt();
        test_decrypt();
        test_pad();
        test_err_char();
        test_key_busy();
        test_stall();
        test_two_blocks();
        test_mid_reset();
        test_case_fold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

endmodule
